dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port 256x16 data memory between the control unit's load/store path and a DMA/debug port. Each requester holds a level request until a one-cycle done pulse. The arbiter grants one access at a time and drives the memory strobes. It returns read data to the owner. It sits between the control unit's D_addr/D_rd/D_wr outputs and the data memory.

---
 rtl/dmem_arbiter_if.sv | 55 +++++
 rtl/dmem_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports and the data-memory port
// that the dmem_arbiter shares.
//   slave  : arbiter view (takes requests, drives memory strobes, returns data)
//   master : environment view (requesters and the synchronous RAM)
// Signals:
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata -> arbiter, cpu_rdata/cpu_done <- arbiter
//   dma_rd/dma_wr/dma_addr/dma_wdata -> arbiter, dma_rdata/dma_done <- arbiter
//   mem_addr/mem_rd/mem_wr/mem_wdata <- arbiter, mem_rdata -> arbiter
//   busy <- arbiter (high while an access is in flight)
interface dmem_arbiter_if #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
);
  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_done;

  logic          dma_rd;
  logic          dma_wr;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_done;

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_done,
    input  dma_rd, dma_wr, dma_addr, dma_wdata,
    output dma_rdata, dma_done,
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_done,
    output dma_rd, dma_wr, dma_addr, dma_wdata,
    input  dma_rdata, dma_done,
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data memory between the
// CPU load/store path and a DMA/debug port. One access at a time, 3 cycles
// each (IDLE grant, ACCESS strobe, RESP done + read data).
// Ports:
//   clk  - rising-edge clock
//   clr  - asynchronous active-high reset
//   bus  - dmem_arbiter_if.slave (requesters, memory port, busy)
// Build option:
//   DMEM_ARB_RR_EN defined   -> round-robin on ties (last-grant pointer)
//   DMEM_ARB_RR_EN undefined -> fixed priority, CPU wins ties
module dmem_arbiter #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16
) (
  input  logic             clk,
  input  logic             clr,
  dmem_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;

  logic          cpu_req;
  logic          dma_req;
  logic          any_req;
  logic          grant_dma;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  logic          owner_dma_q;
  logic          op_wr_q;

  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_rd_q,    mem_rd_d;
  logic          mem_wr_q,    mem_wr_d;
  logic          cpu_done_q,  cpu_done_d;
  logic          dma_done_q,  dma_done_d;
  logic          busy_q,      busy_d;

  logic [DW-1:0] cpu_rdata_q, cpu_rdata_c;
  logic [DW-1:0] dma_rdata_q, dma_rdata_c;
  logic          rd_resp;

  assign cpu_req = bus.cpu_rd | bus.cpu_wr;
  assign dma_req = bus.dma_rd | bus.dma_wr;
  assign any_req = cpu_req | dma_req;

`ifdef DMEM_ARB_RR_EN
  // Last-grant pointer: 1 = DMA was granted last. Reset to DMA so CPU wins the first tie.
  logic last_dma_q;

  assign grant_dma = dma_req & (~cpu_req | ~last_dma_q);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      last_dma_q <= 1'b1;
    end else if (state_q == S_IDLE && any_req) begin
      last_dma_q <= grant_dma;
    end
  end
`else
  assign grant_dma = dma_req & ~cpu_req;
`endif

  // Winner's request fields; write takes precedence when rd and wr are both high.
  assign sel_wr    = grant_dma ? bus.dma_wr    : bus.cpu_wr;
  assign sel_addr  = grant_dma ? bus.dma_addr  : bus.cpu_addr;
  assign sel_wdata = grant_dma ? bus.dma_wdata : bus.cpu_wdata;

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (any_req) state_d = S_ACCESS;
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic, evaluated on the next state so every output is a flop.
  // ACCESS is only entered from IDLE, so the winner's fields are latched here.
  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    cpu_done_d  = 1'b0;
    dma_done_d  = 1'b0;
    busy_d      = 1'b0;
    unique case (state_d)
      S_ACCESS: begin
        mem_addr_d  = sel_addr;
        mem_wdata_d = sel_wdata;
        mem_rd_d    = ~sel_wr;
        mem_wr_d    = sel_wr;
        busy_d      = 1'b1;
      end
      S_RESP: begin
        cpu_done_d  = ~owner_dma_q;
        dma_done_d  = owner_dma_q;
        busy_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      cpu_done_q  <= cpu_done_d;
      dma_done_q  <= dma_done_d;
      busy_q      <= busy_d;
    end
  end

  // Owner and operation of the access in flight
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      owner_dma_q <= 1'b0;
      op_wr_q     <= 1'b0;
    end else if (state_q == S_IDLE && any_req) begin
      owner_dma_q <= grant_dma;
      op_wr_q     <= sel_wr;
    end
  end

  assign rd_resp = (state_q == S_RESP) && !op_wr_q;

  // Read data capture at the end of RESP
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else if (rd_resp) begin
      if (owner_dma_q) dma_rdata_q <= bus.mem_rdata;
      else             cpu_rdata_q <= bus.mem_rdata;
    end
  end

  // RAM data flows straight through during the done cycle, held otherwise
  always_comb begin
    cpu_rdata_c = cpu_rdata_q;
    dma_rdata_c = dma_rdata_q;
    if (rd_resp) begin
      if (owner_dma_q) dma_rdata_c = bus.mem_rdata;
      else             cpu_rdata_c = bus.mem_rdata;
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.dma_done  = dma_done_q;
  assign bus.busy      = busy_q;
  assign bus.cpu_rdata = cpu_rdata_c;
  assign bus.dma_rdata = dma_rdata_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: synchronous 256x16 RAM model, reference memory,
// and an expected-grant queue popped on each done pulse.
module tb_dmem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   ram_clr = 1'b1;
  bit   hold_reqs = 1'b0;

  logic [DW-1:0] ram     [256];
  logic [DW-1:0] ref_mem [256];

  typedef struct {
    bit            dma;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cycle;
  } exp_t;
  exp_t sb[$];

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  dmem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: read data valid the cycle after mem_rd
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= '0;
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  task automatic drive_req(input bit dma, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (dma) begin
      bus.dma_rd = rd; bus.dma_wr = wr; bus.dma_addr = a; bus.dma_wdata = d;
    end else begin
      bus.cpu_rd = rd; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  // Waits (bounded) for a done pulse and checks it against the queue head.
  task automatic wait_done(input int budget, input string name);
    bit got;
    exp_t e;
    logic [DW-1:0] act;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (bus.cpu_done || bus.dma_done) begin
        got = 1'b1;
        n_cmp++;
        if (bus.cpu_done && bus.dma_done) begin
          n_err++;
          $display("FAIL %s done_overlap: cpu_done=1 dma_done=1, required one only", name);
        end
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL %s unexpected_done at cycle %0d", name, cyc);
        end else begin
          e = sb.pop_front();
          if (bus.dma_done !== e.dma) begin
            n_err++;
            $display("FAIL %s owner: dma_done=%0b required %0b", name, bus.dma_done, e.dma);
          end
          n_cmp++;
          if (cyc !== e.cycle) begin
            n_err++;
            $display("FAIL %s done_cycle: got %0d required %0d", name, cyc, e.cycle);
          end
          if (!e.wr) begin
            act = e.dma ? bus.dma_rdata : bus.cpu_rdata;
            n_cmp++;
            if (act !== e.data) begin
              n_err++;
              $display("FAIL %s rdata@done: got %h required %h", name, act, e.data);
            end
          end
        end
        if (!hold_reqs) begin
          if (bus.dma_done) drive_req(1'b1, 1'b0, 1'b0, '0, '0);
          if (bus.cpu_done) drive_req(1'b0, 1'b0, 1'b0, '0, '0);
        end
      end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: no done within %0d cycles", name, budget);
    end
  endtask

  // One access from an otherwise idle requester pair
  task automatic single_access(input bit dma, input bit rd, input bit wr,
                               input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input string name);
    exp_t e;
    logic [DW-1:0] prev;
    logic [DW-1:0] act;
    @(negedge clk);
    prev    = dma ? bus.dma_rdata : bus.cpu_rdata;
    e.dma   = dma;
    e.wr    = wr;
    e.addr  = a;
    e.data  = wr ? d : ref_mem[a];
    e.cycle = cyc + 2;
    if (wr) ref_mem[a] = d;
    sb.push_back(e);
    drive_req(dma, rd, wr, a, d);
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_rd, bus.mem_wr} !== {~wr, wr}) begin
      n_err++;
      $display("FAIL %s strobes: rd/wr=%b%b required %b%b", name, bus.mem_rd, bus.mem_wr, ~wr, wr);
    end
    n_cmp++;
    if (bus.mem_addr !== a) begin
      n_err++;
      $display("FAIL %s mem_addr: got %h required %h", name, bus.mem_addr, a);
    end
    if (wr) begin
      n_cmp++;
      if (bus.mem_wdata !== d) begin
        n_err++;
        $display("FAIL %s mem_wdata: got %h required %h", name, bus.mem_wdata, d);
      end
    end
    n_cmp++;
    if ({bus.busy, bus.cpu_done, bus.dma_done} !== 3'b100) begin
      n_err++;
      $display("FAIL %s access_flags: busy/cdone/ddone=%b required 100", name,
               {bus.busy, bus.cpu_done, bus.dma_done});
    end
    wait_done(4, name);
    @(negedge clk);
    act = dma ? bus.dma_rdata : bus.cpu_rdata;
    n_cmp++;
    if (act !== (wr ? prev : e.data)) begin
      n_err++;
      $display("FAIL %s rdata_hold: got %h required %h", name, act, wr ? prev : e.data);
    end
    n_cmp++;
    if ({bus.busy, bus.cpu_done, bus.dma_done, bus.mem_rd, bus.mem_wr} !== 5'b0 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      n_err++;
      $display("FAIL %s idle_outputs: busy=%b done=%b%b strobes=%b%b addr=%h wdata=%h required all 0",
               name, bus.busy, bus.cpu_done, bus.dma_done, bus.mem_rd, bus.mem_wr,
               bus.mem_addr, bus.mem_wdata);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1; ram_clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_rd, bus.mem_wr, bus.cpu_done, bus.dma_done, bus.busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 00000",
               {bus.mem_rd, bus.mem_wr, bus.cpu_done, bus.dma_done, bus.busy});
    end
    n_cmp++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
      n_err++;
      $display("FAIL reset_mem_bus: addr=%h wdata=%h required 0", bus.mem_addr, bus.mem_wdata);
    end
    n_cmp++;
    if (bus.cpu_rdata !== '0 || bus.dma_rdata !== '0) begin
      n_err++;
      $display("FAIL reset_rdata: cpu=%h dma=%h required 0", bus.cpu_rdata, bus.dma_rdata);
    end
    clr = 1'b0; ram_clr = 1'b0;
  endtask

  task automatic test_cpu_write_read();
    single_access(1'b0, 1'b0, 1'b1, 8'h05, 16'hBEEF, "cpu_wr_05");
    single_access(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000, "cpu_rd_05");
  endtask

  task automatic test_rd_wr_both();
    n_cmp++;
    if (bus.dma_rdata !== '0) begin
      n_err++;
      $display("FAIL dma_rdata_pre: got %h required 0000", bus.dma_rdata);
    end
    single_access(1'b1, 1'b1, 1'b1, 8'h33, 16'h1234, "dma_rdwr_33");
  endtask

  task automatic test_contention();
    exp_t e;
    single_access(1'b1, 1'b0, 1'b1, 8'h10, 16'h1111, "dma_wr_10");
    @(negedge clk);
    e.dma = 1'b0; e.wr = 1'b0; e.addr = 8'h10; e.data = ref_mem[8'h10]; e.cycle = cyc + 2;
    sb.push_back(e);
    e.dma = 1'b1; e.wr = 1'b1; e.addr = 8'h20; e.data = 16'h5A5A; e.cycle = cyc + 5;
    sb.push_back(e);
    ref_mem[8'h20] = 16'h5A5A;
    drive_req(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000);
    drive_req(1'b1, 1'b0, 1'b1, 8'h20, 16'h5A5A);
    wait_done(6, "tie_first");
    wait_done(6, "tie_second");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   base;
    hold_reqs = 1'b1;
    @(negedge clk);
    base = cyc;
    for (int k = 0; k < 4; k++) begin
`ifdef DMEM_ARB_RR_EN
      e.dma = (k % 2) == 1;
`else
      e.dma = 1'b0;
`endif
      e.wr    = 1'b0;
      e.addr  = e.dma ? 8'h10 : 8'h05;
      e.data  = ref_mem[e.addr];
      e.cycle = base + 2 + 3 * k;
      sb.push_back(e);
    end
    drive_req(1'b0, 1'b1, 1'b0, 8'h05, 16'h0000);
    drive_req(1'b1, 1'b1, 1'b0, 8'h10, 16'h0000);
    for (int k = 0; k < 4; k++) wait_done(5, "b2b");
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);
    hold_reqs = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_hold();
    exp_t e;
    single_access(1'b0, 1'b0, 1'b1, 8'h01, 16'h0A0A, "cpu_wr_01");
    single_access(1'b0, 1'b0, 1'b1, 8'h02, 16'h0B0B, "cpu_wr_02");
    @(negedge clk);
    e.dma = 1'b0; e.wr = 1'b0; e.addr = 8'h01; e.data = ref_mem[8'h01]; e.cycle = cyc + 2;
    sb.push_back(e);
    drive_req(1'b0, 1'b1, 1'b0, 8'h01, 16'h0000);
    @(posedge clk);
    #1 bus.cpu_addr = 8'h02;
    @(negedge clk);
    n_cmp++;
    if (bus.mem_addr !== 8'h01 || bus.mem_rd !== 1'b1) begin
      n_err++;
      $display("FAIL addr_hold: mem_addr=%h mem_rd=%b required 01 1", bus.mem_addr, bus.mem_rd);
    end
    wait_done(4, "addr_hold_rd");
    @(negedge clk);
    n_cmp++;
    if (bus.cpu_rdata !== 16'h0A0A) begin
      n_err++;
      $display("FAIL addr_hold_rdata: got %h required 0a0a", bus.cpu_rdata);
    end
  endtask

  task automatic test_clr_access();
    bit saw_done;
    @(negedge clk);
    drive_req(1'b0, 1'b0, 1'b1, 8'h40, 16'h5555);
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.mem_wr !== 1'b1) begin
      n_err++;
      $display("FAIL clr_pre_access: mem_wr=%b required 1", bus.mem_wr);
    end
    clr = 1'b1;
    #1;
    n_cmp++;
    if (bus.mem_wr !== 1'b0 || bus.busy !== 1'b0 || bus.cpu_rdata !== '0) begin
      n_err++;
      $display("FAIL clr_in_access: mem_wr=%b busy=%b cpu_rdata=%h required 0 0 0000",
               bus.mem_wr, bus.busy, bus.cpu_rdata);
    end
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    clr = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.cpu_done || bus.dma_done || bus.busy) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL clr_no_done: saw done/busy after clr, required none");
    end
    // Write was aborted before its edge, so 0x40 must still read back 0
    single_access(1'b0, 1'b1, 1'b0, 8'h40, 16'h0000, "cpu_rd_40_after_clr");
  endtask

  initial begin
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    drive_req(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    test_reset();
    test_cpu_write_read();
    test_rd_wr_both();
    test_contention();
    test_back_to_back();
    test_addr_hold();
    test_clr_access();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
